// File: rtl/sram_arbiter_if.sv
// =============================================================================
// sram_arbiter_if : processor, debug/loader and SRAM pin bundle for sram_arbiter
// Revision        : 1.0
// =============================================================================
`default_nettype none

interface sram_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  cpu_req;
   logic                  cpu_we;
   logic [ADDR_WIDTH-1:0] cpu_adr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic [DATA_WIDTH-1:0] cpu_rdata;
   logic                  cpu_ack;

   logic                  dbg_req;
   logic                  dbg_we;
   logic [ADDR_WIDTH-1:0] dbg_adr;
   logic [DATA_WIDTH-1:0] dbg_wdata;
   logic [DATA_WIDTH-1:0] dbg_rdata;
   logic                  dbg_ack;

   logic                  owner;
   logic [ADDR_WIDTH-1:0] sram_adr;
   logic [DATA_WIDTH-1:0] sram_dout;
   logic                  sram_dout_en;
   logic [DATA_WIDTH-1:0] sram_din;
   logic                  sram_ce_n;
   logic                  sram_oe_n;
   logic                  sram_we_n;

   modport slave (
      input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
      output cpu_rdata, cpu_ack,
      input  dbg_req, dbg_we, dbg_adr, dbg_wdata,
      output dbg_rdata, dbg_ack,
      output owner, sram_adr, sram_dout, sram_dout_en,
      input  sram_din,
      output sram_ce_n, sram_oe_n, sram_we_n
   );

   modport master (
      output cpu_req, cpu_we, cpu_adr, cpu_wdata,
      input  cpu_rdata, cpu_ack,
      output dbg_req, dbg_we, dbg_adr, dbg_wdata,
      input  dbg_rdata, dbg_ack,
      input  owner, sram_adr, sram_dout, sram_dout_en,
      output sram_din,
      input  sram_ce_n, sram_oe_n, sram_we_n
   );
endinterface

`default_nettype wire

// File: rtl/sram_arbiter.sv
// =============================================================================
// sram_arbiter : cpu/debug arbiter and strobe sequencer for the external SRAM.
//                Define SRAM_ARB_RR_EN for round-robin instead of dbg priority.
// Revision     : 1.0
// =============================================================================
`default_nettype none

module sram_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int WE_PULSE   = 2
) (
   input  logic          clk,
   input  logic          reset,
   sram_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_A  = 3'd1,
      S_RD_B  = 3'd2,
      S_WR_SU = 3'd3,
      S_WR_PL = 3'd4,
      S_WR_HD = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam int               CNT_W     = 4;
   localparam logic [CNT_W-1:0] C_PL_LAST = CNT_W'(WE_PULSE - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  owner_q, owner_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
   logic                  ce_n_q, ce_n_d;
   logic                  oe_n_q, oe_n_d;
   logic                  we_n_q, we_n_d;
   logic                  dout_en_q, dout_en_d;
   logic                  cpu_ack_q, cpu_ack_d;
   logic                  dbg_ack_q, dbg_ack_d;
   logic                  gnt_dbg, gnt_cpu;

`ifdef SRAM_ARB_RR_EN
   // 1 = debug port was granted last; reset means "cpu last granted"
   logic rr_last_dbg_q, rr_last_dbg_d;

   always_comb begin
      gnt_dbg       = bus.dbg_req && (!bus.cpu_req || !rr_last_dbg_q);
      gnt_cpu       = bus.cpu_req && !gnt_dbg;
      rr_last_dbg_d = rr_last_dbg_q;
      if ((state_q == S_IDLE) && (gnt_dbg || gnt_cpu)) begin
         rr_last_dbg_d = gnt_dbg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_last_dbg_q <= 1'b0;
      end else begin
         rr_last_dbg_q <= rr_last_dbg_d;
      end
   end
`else
   always_comb begin
      gnt_dbg = bus.dbg_req;
      gnt_cpu = bus.cpu_req && !bus.dbg_req;
   end
`endif

   // Next-state: the granted port's request is captured once and then ignored
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      adr_d       = adr_q;
      dout_d      = dout_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (gnt_dbg) begin
               owner_d = 1'b1;
               adr_d   = bus.dbg_adr;
               dout_d  = bus.dbg_wdata;
               state_d = bus.dbg_we ? S_WR_SU : S_RD_A;
            end else if (gnt_cpu) begin
               owner_d = 1'b0;
               adr_d   = bus.cpu_adr;
               dout_d  = bus.cpu_wdata;
               state_d = bus.cpu_we ? S_WR_SU : S_RD_A;
            end
         end
         S_RD_A: state_d = S_RD_B;
         S_RD_B: begin
            state_d = S_DONE;
            if (owner_q) begin
               dbg_rdata_d = bus.sram_din;
            end else begin
               cpu_rdata_d = bus.sram_din;
            end
         end
         S_WR_SU: begin
            state_d = S_WR_PL;
            cnt_d   = '0;
         end
         S_WR_PL: begin
            if (cnt_q == C_PL_LAST) begin
               state_d = S_WR_HD;
            end else begin
               cnt_d = cnt_q + C_CNT_ONE;
            end
         end
         S_WR_HD: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_IDLE) begin
         owner_d = 1'b0;
      end
   end

   // Pin outputs are decoded from the next state so they are registered
   always_comb begin
      ce_n_d    = 1'b1;
      oe_n_d    = 1'b1;
      we_n_d    = 1'b1;
      dout_en_d = 1'b0;
      cpu_ack_d = 1'b0;
      dbg_ack_d = 1'b0;

      case (state_d)
         S_RD_A, S_RD_B: begin
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
         end
         S_WR_SU, S_WR_HD: begin
            ce_n_d    = 1'b0;
            dout_en_d = 1'b1;
         end
         S_WR_PL: begin
            ce_n_d    = 1'b0;
            we_n_d    = 1'b0;
            dout_en_d = 1'b1;
         end
         S_DONE: begin
            cpu_ack_d = !owner_d;
            dbg_ack_d = owner_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         owner_q     <= 1'b0;
         adr_q       <= '0;
         dout_q      <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         dout_en_q   <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dbg_ack_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         adr_q       <= adr_d;
         dout_q      <= dout_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         dout_en_q   <= dout_en_d;
         cpu_ack_q   <= cpu_ack_d;
         dbg_ack_q   <= dbg_ack_d;
      end
   end

   assign bus.cpu_rdata    = cpu_rdata_q;
   assign bus.cpu_ack      = cpu_ack_q;
   assign bus.dbg_rdata    = dbg_rdata_q;
   assign bus.dbg_ack      = dbg_ack_q;
   assign bus.owner        = owner_q;
   assign bus.sram_adr     = adr_q;
   assign bus.sram_dout    = dout_q;
   assign bus.sram_dout_en = dout_en_q;
   assign bus.sram_ce_n    = ce_n_q;
   assign bus.sram_oe_n    = oe_n_q;
   assign bus.sram_we_n    = we_n_q;

endmodule

`default_nettype wire
